// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared bus widths, ROM enable levels, reset pc, fetch FSM states and queue entry layout
package inst_fetch_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic {IDLE, RUN} state_e;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic adel;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch bundle (pipeline control stall/redirect in, ROM ce/addr out + inst in, decode valid/pc/inst/adel out + ready in); master=fetch, slave=environment
interface inst_fetch_if;
  import inst_fetch_pkg::*;
  logic stall_i;
  logic redirect_i;
  logic [INST_ADDR_W-1:0] redirect_pc_i;
  logic rom_ce_o;
  logic [INST_ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;
  logic if_valid_o;
  logic [INST_ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0] if_inst_o;
  logic if_adel_o;
  logic if_ready_i;
  modport master (
    input stall_i, redirect_i, redirect_pc_i, rom_inst_i, if_ready_i,
    output rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o, if_adel_o
  );
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, rom_inst_i, if_ready_i,
    input rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o, if_adel_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: registered FIFO (clk, rst async, flush, push/push_data, pop/head_data, full, empty); DEPTH must be a power of two
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic [WIDTH-1:0] push_data,
  input  logic pop,
  output logic [WIDTH-1:0] head_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = push_data;
    rd_d = flush ? '0 : rd_q + AW'(pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign head_data = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: pc register + IDLE/RUN fetch FSM feeding fetch_queue (clk, rst async, bus: inst_fetch_if.master)
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int QDEPTH = 2,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic clk,
  input logic rst,
  inst_fetch_if.master bus
);
  state_e state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic halt_q, halt_d;
  logic full, empty, pop, fetch, mis;
  entry_t push_data, head;
  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(ENTRY_W)) u_queue (
    .clk(clk),
    .rst(rst),
    .flush(bus.redirect_i),
    .push(fetch),
    .push_data(push_data),
    .pop(pop),
    .head_data(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = RUN;
    pop = !empty && bus.if_ready_i;
    mis = pc_q[1:0] != 2'b00;
    fetch = state_q == RUN && !bus.redirect_i && !bus.stall_i && !halt_q && (!full || pop);
    push_data = {pc_q, mis ? ZERO_WORD : bus.rom_inst_i, mis};
    pc_d = bus.redirect_i ? bus.redirect_pc_i : (fetch && !mis) ? pc_q + 32'd4 : pc_q;
    halt_d = bus.redirect_i ? 1'b0 : halt_q || (fetch && mis);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      halt_q <= halt_d;
    end
  end
  assign bus.rom_ce_o = (fetch && !mis) ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr_o = pc_q;
  assign bus.if_valid_o = !empty;
  assign bus.if_pc_o = empty ? ZERO_WORD : head.pc;
  assign bus.if_inst_o = empty ? ZERO_WORD : head.inst;
  assign bus.if_adel_o = !empty && head.adel;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter QDEPTH, default 2: fetch queue depth in entries; legal values 2 and 4.
REQ-002 Parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall_i  in  1  pipeline-control hold; no new fetch while high.
REQ-006 redirect_i  in  1  branch/jump/exception redirect request.
REQ-007 redirect_pc_i  in  32  target byte address, valid when redirect_i is high.
REQ-008 rom_ce_o  out  1  instruction ROM chip enable (ChipEnable=1, ChipDisable=0).
REQ-009 rom_addr_o  out  32  instruction ROM byte address.
REQ-010 rom_inst_i  in  32  ROM read data, combinationally valid in the same cycle as rom_addr_o when rom_ce_o=1.
REQ-011 if_valid_o  out  1  queue head holds an instruction.
REQ-012 if_pc_o  out  32  byte address of the head instruction.
REQ-013 if_inst_o  out  32  head instruction word.
REQ-014 if_adel_o  out  1  head was fetched from a misaligned address (address-error-on-load exception).
REQ-015 if_ready_i  in  1  decode accepts the head in this cycle when if_valid_o=1.

Function
REQ-016 States: IDLE (first cycle after reset), RUN. IDLE -> RUN unconditionally after 1 cycle; rom_ce_o=0 in IDLE.
REQ-017 Fetch condition (RUN): redirect_i=0, stall_i=0, and the queue is not full or a pop occurs in the same cycle.
REQ-018 When the fetch condition holds: rom_ce_o=1, rom_addr_o=pc, push {pc, rom_inst_i, adel=0}, pc <= pc+4; otherwise rom_ce_o=0.
REQ-019 rom_addr_o SHALL equal pc whenever rom_ce_o=1 and SHALL hold pc when rom_ce_o=0.
REQ-020 If pc[1:0] != 0, the fetch condition instead pushes {pc, 32'h0, adel=1} with rom_ce_o=0; pc does not advance; no further pushes occur until a redirect.
REQ-021 Pop: if_valid_o & if_ready_i removes the head at the clock edge; the queue is first-in, first-out.
REQ-022 Latency: an instruction fetched in cycle N appears at the head no earlier than cycle N+1 (registered queue).
REQ-023 Head outputs SHALL be stable while if_valid_o=1 and if_ready_i=0.
REQ-024 Push and pop in the same cycle with the queue full SHALL be legal; occupancy is unchanged.
REQ-025 Redirect: flush all queue entries, pc <= redirect_pc_i, no push that cycle; if_valid_o=0 in cycle N+1.
REQ-026 Redirect has priority over stall_i and over a full queue; a pop coincident with a redirect is accepted, and everything else is flushed.
REQ-027 Decode asserts redirect_i only after it has accepted the delay-slot instruction; this block does no delay-slot tracking.
REQ-028 pc wraps modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-029 A stall held for any number of cycles SHALL lose no instruction and duplicate none.

Reset
REQ-030 While rst=1: rom_ce_o=0, rom_addr_o=RESET_PC, pc=RESET_PC, queue empty, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_adel_o=0, state=IDLE.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronously).

Structure
REQ-032 Bus widths (InstAddrBus, InstBus), ZeroWord, ChipEnable/ChipDisable and the RESET_PC default come from the shared defines file.
REQ-033 The queue SHALL be a sub-module fetch_queue (parameterised depth and width, with flush, push, pop and full/empty signals).
REQ-034 The fetch state machine and pc register reside in inst_fetch.

Verification
REQ-035 Reset release with if_ready_i=1 and the ROM holding word k = 32'h1000_0000+k -> rom_ce_o=0 in cycle 1; heads at PC 0, 4, 8 carry 32'h10000000, 32'h10000001, 32'h10000002 on consecutive cycles.
REQ-036 if_ready_i=0 for 5 cycles -> exactly QDEPTH pushes, then rom_ce_o=0 with the head held at PC 0; releasing if_ready_i resumes with no gap or duplicate.
REQ-037 redirect_i=1 with redirect_pc_i=32'h0000_0100 while the queue is full and stall_i=1 -> next cycle if_valid_o=0, rom_addr_o=32'h100; the following head has if_pc_o=32'h100.
REQ-038 redirect_pc_i=32'h0000_0102 -> one entry with if_adel_o=1, if_inst_o=0, if_pc_o=32'h102; rom_ce_o stays 0 until the next redirect.
REQ-039 pc forced to 32'hFFFFFFF8 via redirect -> head PCs FFFFFFF8, FFFFFFFC, 00000000.
REQ-040 rst pulsed while two entries are queued -> if_valid_o falls without waiting for a clock edge; fetch restarts at RESET_PC after one IDLE cycle.
